// File: rtl/mmio_timer.sv
// Memory-mapped down-counter timer with CTRL/PRESET/COUNT registers.
// The counter reloads from PRESET and raises an interrupt flag on expiry, once or periodically.
module mmio_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic        RE,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg, ctrl_next;
    logic [31:0] preset_reg, preset_next;
    logic [31:0] count_reg, count_next;
    logic        irq_flag_reg, irq_flag_next;
    logic        irq_set;
    logic [1:0]  wr_sel;

    logic        enable;
    logic        mode_reload;
    logic        addr_unused;

    assign enable      = ctrl_reg[0];
    assign mode_reload = (ctrl_reg[2:1] == 2'd1);
    assign addr_unused = ^{A[31:4], A[1:0]};

    // Store strobes for the two writable registers (CTRL, PRESET).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wr_sel
            assign wr_sel[gi] = WE && (A[3:2] == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            ctrl_reg     <= 4'd0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            preset_reg   <= preset_next;
            count_reg    <= count_next;
            irq_flag_reg <= irq_flag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (enable) state_next = LOAD;
            LOAD: state_next = CNT;
            CNT: begin
                if (!enable)
                    state_next = IDLE;
                else if (count_reg <= 32'd1)
                    state_next = INT;
            end
            INT: state_next = mode_reload ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ctrl_next     = ctrl_reg;
        preset_next   = wr_sel[1] ? WD : preset_reg;
        count_next    = count_reg;
        irq_flag_next = irq_flag_reg;
        irq_set       = 1'b0;
        case (state_reg)
            LOAD: count_next = preset_reg;
            CNT: begin
                if (enable) begin
                    if (count_reg > 32'd1) begin
                        count_next = count_reg - 32'd1;
                    end else begin
                        count_next = 32'd0;
                        irq_set    = 1'b1;
                    end
                end
            end
            INT: begin
                if (mode_reload)
                    irq_flag_next = 1'b0;
                else
                    ctrl_next[0] = 1'b0;
            end
            default: ;
        endcase
        // A CTRL store overrides the one-shot Enable clear; an expiry on the same edge keeps the flag.
        if (wr_sel[0]) begin
            ctrl_next     = WD[3:0];
            irq_flag_next = 1'b0;
        end
        if (irq_set)
            irq_flag_next = 1'b1;
    end

    always_comb begin
        RD = 32'd0;
        if (RE) begin
            case (A[3:2])
                ADDR_CTRL:   RD = {28'd0, ctrl_reg};
                ADDR_PRESET: RD = preset_reg;
                ADDR_COUNT:  RD = count_reg;
                default:     RD = 32'd0;
            endcase
        end
    end

    assign IRQ = irq_flag_reg & ctrl_reg[3];

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized runs
// compared against an arithmetic timeline model of the timer.
module tb_mmio_timer;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] WD;
    logic        WE;
    logic        RE;
    logic [31:0] RD;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    mmio_timer dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .WD    (WD),
        .WE    (WE),
        .RE    (RE),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        WE    = 1'b0;
        RE    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Store sampled at the next rising edge (t0); returns 1ns after that edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        A  = addr;
        WD = data;
        WE = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        $display("store A=%h WD=%h", addr, data);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        WE = 1'b0;
        RE = 1'b1;
        A  = 32'h0;
        WD = 32'h0;
        #3;
        for (int r = 0; r < 3; r++) begin
            A = 32'(r) << 2;
            #1;
            n_cmp++;
            if (RD !== 32'd0) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h expected %h", r, RD, 32'd0);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected 0", IRQ);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mode0();
        logic [31:0] exp;
        pulse_reset();
        store(32'h4, 32'd5);
        store(32'h0, 32'h9);
        RE = 1'b1;
        A  = 32'h8;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            exp = (c < 2 || c >= 7) ? 32'd0 : 32'(5 - (c - 2));
            n_cmp++;
            if (RD !== exp) begin
                n_err++;
                $display("FAIL mode0_count c=%0d: got %0d expected %0d", c, RD, exp);
            end
            n_cmp++;
            if (IRQ !== (c >= 7)) begin
                n_err++;
                $display("FAIL mode0_irq c=%0d: got %b expected %b", c, IRQ, (c >= 7));
            end
        end
        A = 32'h0;
        #1;
        n_cmp++;
        if (RD !== 32'h8) begin
            n_err++;
            $display("FAIL mode0_ctrl: got %h expected %h", RD, 32'h8);
        end
        store(32'h0, 32'h8);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL mode0_irq_clear: got %b expected 0", IRQ);
        end
    endtask

    task automatic test_mode1();
        logic exp_irq;
        pulse_reset();
        store(32'h4, 32'd3);
        store(32'h0, 32'hB);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            exp_irq = (c >= 5) && ((c - 5) % 5 == 0);
            n_cmp++;
            if (IRQ !== exp_irq) begin
                n_err++;
                $display("FAIL mode1_irq c=%0d: got %b expected %b", c, IRQ, exp_irq);
            end
        end
    endtask

    task automatic test_no_im();
        logic [31:0] exp;
        pulse_reset();
        store(32'h4, 32'd2);
        store(32'h0, 32'h1);
        RE = 1'b1;
        A  = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            exp = (c >= 5) ? 32'h0 : 32'h1;
            n_cmp++;
            if (RD !== exp || IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL no_im c=%0d: got ctrl=%h irq=%b expected ctrl=%h irq=0", c, RD, IRQ, exp);
            end
        end
        A = 32'h8;
        #1;
        n_cmp++;
        if (RD !== 32'd0) begin
            n_err++;
            $display("FAIL no_im_count: got %0d expected 0", RD);
        end
    endtask

    task automatic test_preset_midcount();
        logic [31:0] exp_cnt [1:17];
        exp_cnt = '{32'd0, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
                    32'd4, 32'd3, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2};
        pulse_reset();
        store(32'h4, 32'd6);
        store(32'h0, 32'hB);
        RE = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            if (c == 7) begin
                A = 32'h4; WD = 32'd4; WE = 1'b1;
            end else if (c == 12) begin
                A = 32'h0; WD = 32'hA; WE = 1'b1;
            end
            @(posedge clk);
            #1;
            WE = 1'b0;
            A  = 32'h8;
            #1;
            n_cmp++;
            if (RD !== exp_cnt[c]) begin
                n_err++;
                $display("FAIL preset_mid_count c=%0d: got %0d expected %0d", c, RD, exp_cnt[c]);
            end
            n_cmp++;
            if (IRQ !== (c == 8)) begin
                n_err++;
                $display("FAIL preset_mid_irq c=%0d: got %b expected %b", c, IRQ, (c == 8));
            end
        end
    endtask

    task automatic test_preset0();
        pulse_reset();
        store(32'h4, 32'd0);
        store(32'h0, 32'h9);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (IRQ !== (c >= 3)) begin
                n_err++;
                $display("FAIL preset0_irq c=%0d: got %b expected %b", c, IRQ, (c >= 3));
            end
        end
        RE = 1'b1;
        A  = 32'h0;
        #1;
        n_cmp++;
        if (RD !== 32'h8) begin
            n_err++;
            $display("FAIL preset0_ctrl: got %h expected %h", RD, 32'h8);
        end
        A = 32'hC;
        #1;
        n_cmp++;
        if (RD !== 32'd0) begin
            n_err++;
            $display("FAIL reserved_read: got %h expected 0", RD);
        end
        RE = 1'b0;
        A  = 32'h0;
        #1;
        n_cmp++;
        if (RD !== 32'd0) begin
            n_err++;
            $display("FAIL re0_read: got %h expected 0", RD);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_cnt [1:9];
        exp_cnt = '{32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
        pulse_reset();
        store(32'h4, 32'd2);
        store(32'h0, 32'h9);
        RE = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 4 || c == 5) begin
                A = 32'h0; WD = 32'h9; WE = 1'b1;
            end
            @(posedge clk);
            #1;
            WE = 1'b0;
            A  = 32'h8;
            #1;
            n_cmp++;
            if (RD !== exp_cnt[c]) begin
                n_err++;
                $display("FAIL b2b_count c=%0d: got %0d expected %0d", c, RD, exp_cnt[c]);
            end
            n_cmp++;
            if (IRQ !== (c == 4 || c == 9)) begin
                n_err++;
                $display("FAIL b2b_irq c=%0d: got %b expected %b", c, IRQ, (c == 4 || c == 9));
            end
        end
    endtask

    task automatic test_reset_midcount();
        pulse_reset();
        store(32'h4, 32'd2);
        store(32'h0, 32'h9);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre_irq: got %b expected 1", IRQ);
        end
        #2;
        reset = 1'b0;
        RE = 1'b1;
        #1;
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_irq: got %b expected 0", IRQ);
        end
        for (int r = 0; r < 3; r++) begin
            A = 32'(r) << 2;
            #1;
            n_cmp++;
            if (RD !== 32'd0) begin
                n_err++;
                $display("FAIL rst_mid_reg%0d: got %h expected 0", r, RD);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        A = 32'h8;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (IRQ !== 1'b0 || RD !== 32'd0) begin
                n_err++;
                $display("FAIL rst_mid_after c=%0d: got irq=%b count=%0d expected irq=0 count=0", c, IRQ, RD);
            end
        end
    endtask

    // Reference: with t0 = Enable store edge, N1 = max(N,1), LOAD occupies
    // t0+1 and the count starts at t0+2; a Mode-1 cycle repeats every N1+2.
    task automatic test_random();
        int unsigned n, n1, per, mode, im, sel, r, cnt;
        logic        exp_irq;
        logic        en;
        logic [31:0] exp;
        for (int it = 0; it < 10; it++) begin
            n    = $urandom_range(0, 12);
            mode = $urandom_range(0, 3);
            im   = $urandom_range(0, 1);
            n1   = (n == 0) ? 1 : n;
            per  = n1 + 2;
            pulse_reset();
            store(32'h4, n);
            store(32'h0, {28'd0, im[0], mode[1:0], 1'b1});
            RE = 1'b1;
            for (int c = 1; c <= int'(3 * per + 2); c++) begin
                @(posedge clk);
                #1;
                sel = $urandom_range(0, 2);
                A = sel << 2;
                #1;
                if (c < 2) begin
                    cnt = 0; exp_irq = 1'b0; en = 1'b1;
                end else if (mode == 1) begin
                    r = (c - 2) % per;
                    cnt = (r < n) ? n - r : 0;
                    exp_irq = (im == 1) && (r == n1);
                    en = 1'b1;
                end else begin
                    r = c - 2;
                    cnt = (r < n) ? n - r : 0;
                    exp_irq = (im == 1) && (c >= int'(n1 + 2));
                    en = (c < int'(n1 + 3));
                end
                case (sel)
                    0:       exp = {28'd0, im[0], mode[1:0], en};
                    1:       exp = n;
                    default: exp = cnt;
                endcase
                n_cmp++;
                if (RD !== exp || IRQ !== exp_irq) begin
                    n_err++;
                    $display("FAIL random it=%0d N=%0d mode=%0d c=%0d reg=%0d: got rd=%0d irq=%b expected rd=%0d irq=%b",
                             it, n, mode, c, sel, RD, IRQ, exp, exp_irq);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_no_im();
        test_preset_midcount();
        test_preset0();
        test_back_to_back();
        test_reset_midcount();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately, independent of clk).
REQ-003 SHALL have port: A  input  32  word byte-address from stage M; only A[3:2] decoded.
REQ-004 SHALL have port: WD  input  32  store data.
REQ-005 SHALL have port: WE  input  1  store strobe, sampled at rising clk.
REQ-006 SHALL have port: RE  input  1  load strobe.
REQ-007 SHALL have port: RD  output  32  load data, combinational.
REQ-008 SHALL have port: IRQ  output  1  interrupt request to CP0.

Function
REQ-009 SHALL decode registers: A[3:2]=0 CTRL (r/w), 1 PRESET (r/w), 2 COUNT (read-only), 3 reserved.
REQ-010 SHALL define CTRL[0]=Enable, CTRL[2:1]=Mode, CTRL[3]=IM; CTRL[31:4] read 0, ignored on write.
REQ-011 SHALL drive RD = selected register when RE=1; RD=0 when RE=0 or A[3:2]=3; same-cycle read returns pre-edge value.
REQ-012 SHALL ignore stores to COUNT and to the reserved address.
REQ-013 SHALL implement FSM states IDLE, LOAD, CNT, INT; state is internal only.
REQ-014 SHALL, in IDLE: Enable=1 -> LOAD; otherwise stay; COUNT held.
REQ-015 SHALL, in LOAD: COUNT<=PRESET, -> CNT (one cycle).
REQ-016 SHALL, in CNT: Enable=0 -> IDLE, COUNT held; else COUNT>1 -> COUNT-1, stay; else (COUNT<=1) COUNT<=0, irq_flag<=1, -> INT.
REQ-017 SHALL, in INT with Mode=0: clear Enable, -> IDLE; irq_flag stays 1 until a store to CTRL.
REQ-018 SHALL, in INT with Mode=1: -> LOAD and clear irq_flag, giving a one-cycle irq_flag pulse; period = PRESET+2 cycles.
REQ-019 SHALL treat Mode values 2 and 3 as Mode=0.
REQ-020 SHALL drive IRQ = irq_flag AND IM (combinational from registers).
REQ-021 SHALL clear irq_flag on any store to CTRL, unless INT entry occurs on the same edge (set wins).
REQ-022 SHALL give a CTRL store precedence over the FSM's Enable clear on the same edge.
REQ-023 SHALL NOT disturb an in-progress count on a PRESET store; new value takes effect at the next LOAD.
REQ-024 SHALL treat PRESET=0 like PRESET=1 (INT reached one cycle after LOAD).
REQ-025 SHALL give latency: Enable store at edge t0, PRESET=N>=1 -> LOAD at t0+1, COUNT=N at t0+2, irq_flag=1 at t0+N+2.
REQ-026 SHALL use unsigned 32-bit COUNT; no wrap below 0.

Reset
REQ-027 SHALL, while reset=0, hold CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0; RD follows REQ-011 with these values.
REQ-028 SHALL abort any count on mid-operation reset assertion; after release, stay in IDLE until Enable is stored.

Verification
REQ-029 SHALL check: reset pulse low mid-count -> all registers read 0, IRQ=0 immediately, no IRQ after release.
REQ-030 SHALL check: PRESET=5, CTRL=0x9 (Mode0, IM, En) at t0 -> COUNT reads 5,4,3,2,1,0 over t0+2..t0+7; IRQ=1 from t0+7; CTRL reads 0x8; IRQ persists until CTRL store, then 0.
REQ-031 SHALL check: PRESET=3, CTRL=0xB (Mode1) -> IRQ one-cycle pulses every 5 cycles, repeating indefinitely.
REQ-032 SHALL check: CTRL=0x1 (IM=0), PRESET=2 -> count completes, IRQ stays 0, CTRL Enable clears to 0.
REQ-033 SHALL check: PRESET=4 store while COUNT=2 -> current count ends at 0; in Mode1 next reload is 4; Enable=0 store mid-count freezes COUNT.
REQ-034 SHALL check: PRESET=0 Mode0 -> IRQ at t0+3; reads of A=0xC and any read with RE=0 return 0.
